// File: rtl/jpeg_byte_stuffer.sv
// JPEG output stage: buffers 32-bit Huffman words, serializes them MSB-byte-first with
// a 0x00 stuff byte after every 0xFF data byte, and appends the EOI marker on request.
module jpeg_byte_stuffer #(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] word_in,
   input  logic        word_valid,
   input  logic        eoi_req,
   output logic [7:0]  byte_out,
   output logic        byte_valid,
   input  logic        byte_ready,
   output logic        overflow,
   output logic        eoi_done
);
   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND,
      S_STUFF,
      S_EOI_FF,
      S_EOI_D9
   } state_t;

   logic [31:0]   r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_overflow;

   state_t        r_state;
   logic [31:0]   r_hold;
   logic [1:0]    r_idx;
   logic [7:0]    r_byte_out;
   logic          r_byte_valid;
   logic          r_eoi;
   logic          r_eoi_done;

   logic          w_empty;
   logic          w_full;
   logic          w_accept;
   logic          w_word_done;
   logic          w_pop;
   logic          w_push;
   logic [31:0]   w_head;
   logic [7:0]    w_cur_byte;
   logic [7:0]    w_nxt_byte;

   // Byte selection, FIFO status and the pop/push decisions shared by FIFO and FSM
   always_comb begin
      w_cur_byte = r_hold[7:0];
      w_nxt_byte = r_hold[31:24];
      case (r_idx)
         2'd0: begin
            w_cur_byte = r_hold[31:24];
            w_nxt_byte = r_hold[23:16];
         end
         2'd1: begin
            w_cur_byte = r_hold[23:16];
            w_nxt_byte = r_hold[15:8];
         end
         2'd2: begin
            w_cur_byte = r_hold[15:8];
            w_nxt_byte = r_hold[7:0];
         end
         default: begin
            w_cur_byte = r_hold[7:0];
            w_nxt_byte = r_hold[31:24];
         end
      endcase
      w_empty     = (r_count == '0);
      w_full      = (r_count == CW'(FIFO_DEPTH));
      w_head      = r_mem[r_rd_ptr];
      w_accept    = r_byte_valid & byte_ready;
      // Final byte of a word (including its stuff byte) is leaving this cycle
      w_word_done = w_accept && (r_idx == 2'd3) &&
                    ((r_state == S_SEND && w_cur_byte != 8'hFF) || r_state == S_STUFF);
      w_pop       = !w_empty && ((r_state == S_IDLE) || w_word_done);
      w_push      = word_valid && (!w_full || w_pop);
   end

   always_ff @(posedge clk) begin
      if (!rst && w_push) begin
         r_mem[r_wr_ptr] <= word_in;
      end
   end

   // Word FIFO pointers, occupancy and sticky overflow
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (word_valid && !w_push) r_overflow <= 1'b1;
      end
   end

   // Serializer FSM with registered byte interface and EOI latch
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_hold       <= '0;
         r_idx        <= '0;
         r_byte_out   <= '0;
         r_byte_valid <= 1'b0;
         r_eoi        <= 1'b0;
         r_eoi_done   <= 1'b0;
      end else begin
         r_eoi_done <= 1'b0;
         if (eoi_req) r_eoi <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (!w_empty) begin
                  r_hold       <= w_head;
                  r_idx        <= '0;
                  r_byte_out   <= w_head[31:24];
                  r_byte_valid <= 1'b1;
                  r_state      <= S_SEND;
               end else if (r_eoi) begin
                  r_byte_out   <= 8'hFF;
                  r_byte_valid <= 1'b1;
                  r_state      <= S_EOI_FF;
               end
            end
            S_SEND, S_STUFF: begin
               if (w_accept) begin
                  if (r_state == S_SEND && w_cur_byte == 8'hFF) begin
                     r_byte_out <= 8'h00;
                     r_state    <= S_STUFF;
                  end else if (r_idx == 2'd3) begin
                     if (!w_empty) begin
                        r_hold     <= w_head;
                        r_idx      <= '0;
                        r_byte_out <= w_head[31:24];
                        r_state    <= S_SEND;
                     end else begin
                        r_byte_valid <= 1'b0;
                        r_state      <= S_IDLE;
                     end
                  end else begin
                     r_idx      <= r_idx + 2'd1;
                     r_byte_out <= w_nxt_byte;
                     r_state    <= S_SEND;
                  end
               end
            end
            S_EOI_FF: begin
               if (w_accept) begin
                  r_byte_out <= 8'hD9;
                  r_state    <= S_EOI_D9;
               end
            end
            S_EOI_D9: begin
               if (w_accept) begin
                  r_byte_valid <= 1'b0;
                  r_eoi_done   <= 1'b1;
                  r_eoi        <= 1'b0;
                  r_state      <= S_IDLE;
               end
            end
            default: begin
               r_byte_valid <= 1'b0;
               r_state      <= S_IDLE;
            end
         endcase
      end
   end

   assign byte_out   = r_byte_out;
   assign byte_valid = r_byte_valid;
   assign overflow   = r_overflow;
   assign eoi_done   = r_eoi_done;

endmodule

// File: tb/tb_jpeg_byte_stuffer.sv
// Bench for jpeg_byte_stuffer: expected byte stream built from stuffing/EOI rules,
// checked on every transfer, plus hand-computed cycle-exact expectations.
module tb_jpeg_byte_stuffer;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] word_in;
   logic        word_valid;
   logic        eoi_req;
   logic [7:0]  byte_out;
   logic        byte_valid;
   logic        byte_ready;
   logic        overflow;
   logic        eoi_done;

   int n_checks = 0;
   int n_errors = 0;

   // {marker flag, byte} in the order the downstream must see them
   logic [8:0] exp_q[$];

   bit         prev_stall = 1'b0;
   logic [7:0] prev_byte  = 8'h00;
   bit         exp_done   = 1'b0;

   logic [7:0] lit1[4] = '{8'h12, 8'h34, 8'h56, 8'h78};
   logic [7:0] lit2[6] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hAB};
   logic [31:0] ovf_words[6] = '{32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4,
                                 32'hD1D2D3D4, 32'hE1E2E3E4, 32'hF1F2F3F4};

   jpeg_byte_stuffer #(.FIFO_DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .word_in    (word_in),
      .word_valid (word_valid),
      .eoi_req    (eoi_req),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .overflow   (overflow),
      .eoi_done   (eoi_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_word(input logic [31:0] w);
      logic [7:0] b;
      for (int i = 3; i >= 0; i--) begin
         b = w[8*i +: 8];
         exp_q.push_back({1'b0, b});
         if (b == 8'hFF) exp_q.push_back(9'h000);
      end
   endtask

   task automatic exp_eoi();
      exp_q.push_back({1'b1, 8'hFF});
      exp_q.push_back({1'b1, 8'hD9});
   endtask

   task automatic push(input logic [31:0] w, input bit accepted);
      word_in    = w;
      word_valid = 1'b1;
      if (accepted) exp_word(w);
      tick();
      word_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      byte_ready = 1'b1;
      while ((exp_q.size() != 0 || byte_valid) && n < 200) begin
         tick();
         n++;
      end
      check(name, 32'(exp_q.size()), 32'd0);
      check({name, "_idle"}, 32'(byte_valid), 32'd0);
   endtask

   // Scoreboard: transfers, stall stability and eoi_done pulse
   always @(negedge clk) begin
      logic [8:0] e;
      if (rst) begin
         prev_stall = 1'b0;
         exp_done   = 1'b0;
      end else begin
         check("eoi_done", 32'(eoi_done), 32'(exp_done));
         exp_done = 1'b0;
         if (prev_stall) begin
            check("hold_valid", 32'(byte_valid), 32'd1);
            check("hold_byte", 32'(byte_out), 32'(prev_byte));
         end
         if (byte_valid && byte_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_byte: got %h expected none at %0t", byte_out, $time);
            end else begin
               e = exp_q.pop_front();
               check("stream_byte", 32'(byte_out), 32'(e[7:0]));
               if (e[8] && e[7:0] == 8'hD9) exp_done = 1'b1;
            end
         end
         prev_stall = byte_valid && !byte_ready;
         prev_byte  = byte_out;
      end
   end

   initial begin
      int n;
      rst        = 1'b1;
      word_in    = '0;
      word_valid = 1'b0;
      eoi_req    = 1'b0;
      byte_ready = 1'b1;
      repeat (3) tick();
      check("rst_valid", 32'(byte_valid), 32'd0);
      check("rst_byte", 32'(byte_out), 32'h00);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_eoi_done", 32'(eoi_done), 32'd0);
      rst = 1'b0;
      tick();

      // Single word, exact cycles
      push(32'h12345678, 1'b1);
      check("w1_c0_valid", 32'(byte_valid), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("w1_valid", 32'(byte_valid), 32'd1);
         check("w1_byte", 32'(byte_out), 32'(lit1[i]));
      end
      tick();
      check("w1_c5_valid", 32'(byte_valid), 32'd0);

      // Stuffing
      push(32'hFF00FFAB, 1'b1);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("stuff_valid", 32'(byte_valid), 32'd1);
         check("stuff_byte", 32'(byte_out), 32'(lit2[i]));
      end
      tick();
      check("stuff_end_valid", 32'(byte_valid), 32'd0);

      // Backpressure
      push(32'h12345678, 1'b1);
      byte_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_valid", 32'(byte_valid), 32'd1);
         check("bp_byte", 32'(byte_out), 32'h12);
      end
      tick();
      byte_ready = 1'b1;
      check("bp_c4_byte", 32'(byte_out), 32'h12);
      for (int i = 1; i < 4; i++) begin
         tick();
         check("bp_rest_byte", 32'(byte_out), 32'(lit1[i]));
      end
      tick();
      check("bp_end_valid", 32'(byte_valid), 32'd0);

      // Overflow: 5 words fit (FIFO + holding register), 6th is dropped
      byte_ready = 1'b0;
      for (int i = 0; i < 5; i++) push(ovf_words[i], 1'b1);
      check("ovf_before", 32'(overflow), 32'd0);
      push(ovf_words[5], 1'b0);
      check("ovf_after", 32'(overflow), 32'd1);
      drain("ovf_drain");
      check("ovf_sticky", 32'(overflow), 32'd1);

      // EOI requested together with the last word
      push(32'h01020304, 1'b1);
      word_in    = 32'hA0B0C0D0;
      word_valid = 1'b1;
      eoi_req    = 1'b1;
      exp_word(32'hA0B0C0D0);
      exp_eoi();
      tick();
      word_valid = 1'b0;
      eoi_req    = 1'b0;
      drain("eoi_drain");

      // EOI with empty FIFO
      eoi_req = 1'b1;
      exp_eoi();
      tick();
      eoi_req = 1'b0;
      drain("eoi2_drain");

      // Word pushed while the marker is stalled must follow the marker
      byte_ready = 1'b0;
      eoi_req    = 1'b1;
      exp_eoi();
      tick();
      eoi_req = 1'b0;
      n = 0;
      while (!byte_valid && n < 10) begin
         tick();
         n++;
      end
      check("eoi3_ff", 32'(byte_out), 32'h000000FF);
      push(32'h77FF8899, 1'b1);
      drain("eoi3_drain");
      check("eoi_ovf_sticky", 32'(overflow), 32'd1);

      // Reset mid-word
      push(32'h11223344, 1'b1);
      tick();
      check("rst_mid_first", 32'(byte_out), 32'h11);
      tick();
      rst = 1'b1;
      exp_q.delete();
      tick();
      rst = 1'b0;
      check("rst_mid_valid", 32'(byte_valid), 32'd0);
      check("rst_mid_overflow", 32'(overflow), 32'd0);
      push(32'h55667788, 1'b1);
      tick();
      check("rst_mid_new", 32'(byte_out), 32'h55);
      drain("rst_mid_drain");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/jpeg_byte_stuffer.md
# jpeg_byte_stuffer

Output stage of the JPEG channel. It consumes the 32-bit `jpeg_bitstream` / `data_valid` word stream produced by the channel's Huffman stage and buffers it in a small word FIFO. It serializes each word MSB-byte-first onto a byte-wide valid/ready interface and inserts a 0x00 stuff byte after every 0xFF data byte. On request, once all buffered data has drained, it appends the EOI marker (0xFF, 0xD9).

## Interface

Parameters:
- `FIFO_DEPTH`, default 4: word FIFO entries; must be a power of 2, minimum 2.

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `word_in` input 32: packed bitstream word; bits [31:24] are transmitted first.
- `word_valid` input 1: `word_in` is valid this cycle; single-cycle qualifier with no backpressure.
- `eoi_req` input 1: single-cycle pulse requesting end-of-image marker insertion.
- `byte_out` output 8: output byte.
- `byte_valid` output 1: `byte_out` is valid.
- `byte_ready` input 1: downstream accepts `byte_out` this cycle.
- `overflow` output 1: sticky flag; a word was dropped.
- `eoi_done` output 1: one-cycle pulse after 0xD9 is accepted.

## Operation

- Clock and reset:
  - One clock domain.
  - Reset is synchronous and active-high.
  - Reset values: `byte_out`=0x00, `byte_valid`=0, `overflow`=0, `eoi_done`=0, FIFO count 0, EOI latch clear, FSM in IDLE.
- Word FIFO:
  - Holds `FIFO_DEPTH` words.
  - Push when `word_valid`=1 and the FIFO is not full, or when it is full and a pop occurs in the same cycle (push and pop together are legal).
  - Push into a full FIFO with no same-cycle pop: the word is dropped and `overflow` is set to 1. `overflow` stays set until `rst`.
- Serializer: a 32-bit holding register plus a 2-bit byte index. It pops the FIFO head into the holding register when in IDLE, or when the last byte of the current word (including its stuff byte) is accepted.
  - Total buffering is `FIFO_DEPTH`+1 words.
- Handshake:
  - A byte transfers on a cycle with `byte_valid`=1 and `byte_ready`=1.
  - While `byte_valid`=1 and `byte_ready`=0, `byte_out` holds stable.
  - `byte_valid` never drops without a transfer, except on `rst`.
- FSM states:
  - IDLE: no byte presented.
    - FIFO non-empty: load the head word and go to SEND.
    - Else if EOI latched: go to EOI_FF.
  - SEND: present byte[index].
    - On acceptance, if the byte is 0xFF, go to STUFF.
    - Else, if index=3: load the next word and stay in SEND if the FIFO is non-empty, else go to IDLE.
    - Else increment index.
  - STUFF: present 0x00. On acceptance, continue exactly as the non-0xFF path of SEND.
  - EOI_FF: present 0xFF (no stuffing). On acceptance, go to EOI_D9.
  - EOI_D9: present 0xD9. On acceptance, pulse `eoi_done` in the next cycle, clear the EOI latch, and go to IDLE.
- EOI latch:
  - `eoi_req` sets the latch.
  - `eoi_req` while the latch is already set is ignored.
  - The marker is emitted only after the FIFO and serializer are empty, so all words pushed before or during the drain precede it.
  - Words pushed during EOI_FF/EOI_D9 are buffered and emitted after the marker.

## Timing

- Latency:
  - A word pushed at edge N into an empty FIFO with the FSM in IDLE presents its first byte with `byte_valid`=1 in cycle N+1.
  - FIFO read is combinational from the head; the load into the holding register occurs at edge N+1.
- Throughput:
  - One byte per cycle while `byte_ready`=1.
  - Non-0xFF word: 4 cycles. Each 0xFF byte adds one cycle.
  - Back-to-back words are gapless in SEND.
- The FIFO pop and the acceptance of a word's final byte occur on the same edge; the next word's byte 0 appears the following cycle.
- `eoi_done` is high for exactly one cycle, the cycle after the 0xD9 transfer.
- `rst` mid-operation discards the FIFO contents, the holding register and the EOI latch. `byte_valid`=0 in the cycle after the reset edge.
- A `word_valid` in a cycle where `rst`=1 is ignored.

## Test plan

- Single word: push 0x12345678 at edge 0, `byte_ready`=1 → `byte_out` is 0x12, 0x34, 0x56, 0x78 in cycles 1–4. `byte_valid`=0 in cycle 5.
- Stuffing: push 0xFF00FFAB → bytes 0xFF, 0x00, 0x00, 0xFF, 0x00, 0xAB over 6 consecutive cycles.
- Backpressure: push 0x12345678 and hold `byte_ready`=0 for cycles 1–3 → `byte_out`=0x12 with `byte_valid`=1 stable in cycles 1–3. Release in cycle 4 → 0x12 transfers in cycle 4; 0x34, 0x56, 0x78 follow in cycles 5–7.
- Overflow, `FIFO_DEPTH`=4:
  - Hold `byte_ready`=0 and push 6 distinct words on consecutive cycles → `overflow`=1 after the 6th push.
  - Release `byte_ready` → exactly the first 5 words appear (20 bytes); the 6th is absent.
  - `overflow` remains 1 until `rst`.
- EOI: push 0x01020304 and 0xA0B0C0D0, with `eoi_req` in the same cycle as the second push → 8 data bytes, then 0xFF, 0xD9, then `eoi_done`=1 for one cycle. A later `eoi_req` with an empty FIFO → 0xFF, 0xD9 starting the next cycle.
- Reset mid-word:
  - Push 0x11223344, assert `rst` after 0x11 transfers → `byte_valid`=0 the next cycle, `overflow`=0.
  - Then push 0x55667788 → 0x55, 0x66, 0x77, 0x88 with no residue from the earlier word.
